// File: rtl/spi_master_arbiter_pkg.sv
// Shared SPI definitions: FSM state types for the SPI blocks and sizing helpers.
package spi_master_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT
   } arb_state_e;

   typedef enum logic [1:0] {
      SPI_IDLE,
      SPI_START,
      SPI_XFER,
      SPI_DONE
   } spi_master_state_e;

   // Index width for n requesters, never narrower than one bit.
   function automatic int addr_bits(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/spi_master_arbiter_rr_select.sv
// Round-robin pick: first asserted request at or above the pointer, wrapping to 0.
module spi_rr_select
   import spi_master_arbiter_pkg::*;
#(
   parameter  int NUM_REQS  = 2,
   localparam int ADDR_BITS = addr_bits(NUM_REQS)
) (
   input  logic [NUM_REQS-1:0]  i_val,
   input  logic [ADDR_BITS-1:0] i_ptr,
   output logic [ADDR_BITS-1:0] o_idx,
   output logic                 o_any_val
);

   logic [NUM_REQS-1:0] w_rot;
   logic [NUM_REQS-1:0] w_scan;
   logic                w_found;
   int unsigned         w_pos;

   always_comb begin
      // Rotating the doubled vector puts requester ptr at bit 0.
      w_rot   = NUM_REQS'({i_val, i_val} >> i_ptr);
      w_scan  = '0;
      w_found = 1'b0;
      w_pos   = 0;
      o_idx   = '0;
      for (int unsigned k = 0; k < NUM_REQS; k++) begin
         w_scan = w_rot >> k;
         if (!w_found && w_scan[0]) begin
            w_found = 1'b1;
            w_pos   = 32'(i_ptr) + k;
            if (w_pos >= NUM_REQS) begin
               w_pos = w_pos - NUM_REQS;
            end
            o_idx = ADDR_BITS'(w_pos);
         end
      end
   end

   assign o_any_val = |i_val;

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one SPI master among NUM_REQS requesters with round-robin grant,
// one request/response transaction at a time.
module spi_master_arbiter
   import spi_master_arbiter_pkg::*;
#(
   parameter  int NBITS     = 32,
   parameter  int NUM_REQS  = 2,
   localparam int ADDR_BITS = addr_bits(NUM_REQS)
) (
   input  logic                      clk,
   input  logic                      reset,

   input  logic [NUM_REQS*NBITS-1:0] req_recv_msg,
   input  logic [NUM_REQS-1:0]       req_recv_val,
   output logic [NUM_REQS-1:0]       req_recv_rdy,

   output logic [NUM_REQS*NBITS-1:0] req_send_msg,
   output logic [NUM_REQS-1:0]       req_send_val,
   input  logic [NUM_REQS-1:0]       req_send_rdy,

   output logic [NBITS-1:0]          spi_send_msg,
   output logic                      spi_send_val,
   input  logic                      spi_send_rdy,

   output logic [ADDR_BITS-1:0]      spi_cs_addr,
   output logic                      spi_cs_addr_val,

   input  logic [NBITS-1:0]          spi_recv_msg,
   input  logic                      spi_recv_val,
   output logic                      spi_recv_rdy
);

   arb_state_e           r_state;
   logic [ADDR_BITS-1:0] r_grant;
   logic [ADDR_BITS-1:0] r_ptr;

   logic [ADDR_BITS-1:0] w_idx;
   logic                 w_any_val;
   logic [ADDR_BITS-1:0] w_next_ptr;
   logic [NUM_REQS-1:0]  w_gmask;
   logic                 w_grant_send_rdy;

   spi_rr_select #(
      .NUM_REQS (NUM_REQS)
   ) u_rr_select (
      .i_val     (req_recv_val),
      .i_ptr     (r_ptr),
      .o_idx     (w_idx),
      .o_any_val (w_any_val)
   );

   assign w_gmask          = NUM_REQS'(1) << r_grant;
   assign w_grant_send_rdy = |(req_send_rdy & w_gmask);
   assign w_next_ptr       = (r_grant == ADDR_BITS'(NUM_REQS - 1)) ? '0 : r_grant + ADDR_BITS'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_ptr   <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_any_val) begin
                  r_grant <= w_idx;
                  r_state <= SEND;
               end
            end
            SEND: begin
               if (spi_send_rdy) begin
                  r_state <= WAIT;
               end
            end
            WAIT: begin
               if (spi_recv_val && w_grant_send_rdy) begin
                  r_state <= IDLE;
                  r_ptr   <= w_next_ptr;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Handshakes pass straight through for the granted requester only.
   always_comb begin
      spi_send_val    = 1'b0;
      spi_cs_addr_val = 1'b0;
      spi_recv_rdy    = 1'b0;
      req_recv_rdy    = '0;
      req_send_val    = '0;
      unique case (r_state)
         SEND: begin
            spi_send_val    = 1'b1;
            spi_cs_addr_val = 1'b1;
            req_recv_rdy    = spi_send_rdy ? w_gmask : '0;
         end
         WAIT: begin
            spi_recv_rdy = w_grant_send_rdy;
            req_send_val = spi_recv_val ? w_gmask : '0;
         end
         default: ;
      endcase
   end

   assign spi_send_msg = NBITS'(req_recv_msg >> (32'(r_grant) * 32'(NBITS)));
   assign spi_cs_addr  = r_grant;
   assign req_send_msg = {NUM_REQS{spi_recv_msg}};

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed and randomized transactions against a round-robin reference model.
module tb_spi_master_arbiter;

   localparam int NB = 32;
   localparam int NR = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [NR*NB-1:0] req_recv_msg;
   logic [NR-1:0]   req_recv_val;
   logic [NR-1:0]   req_recv_rdy;
   logic [NR*NB-1:0] req_send_msg;
   logic [NR-1:0]   req_send_val;
   logic [NR-1:0]   req_send_rdy;
   logic [NB-1:0]   spi_send_msg;
   logic            spi_send_val;
   logic            spi_send_rdy;
   logic [1:0]      spi_cs_addr;
   logic            spi_cs_addr_val;
   logic [NB-1:0]   spi_recv_msg;
   logic            spi_recv_val;
   logic            spi_recv_rdy;

   int checks = 0;
   int errors = 0;
   int m_ptr  = 0;

   spi_master_arbiter #(
      .NBITS    (NB),
      .NUM_REQS (NR)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .req_recv_msg    (req_recv_msg),
      .req_recv_val    (req_recv_val),
      .req_recv_rdy    (req_recv_rdy),
      .req_send_msg    (req_send_msg),
      .req_send_val    (req_send_val),
      .req_send_rdy    (req_send_rdy),
      .spi_send_msg    (spi_send_msg),
      .spi_send_val    (spi_send_val),
      .spi_send_rdy    (spi_send_rdy),
      .spi_cs_addr     (spi_cs_addr),
      .spi_cs_addr_val (spi_cs_addr_val),
      .spi_recv_msg    (spi_recv_msg),
      .spi_recv_val    (spi_recv_val),
      .spi_recv_rdy    (spi_recv_rdy)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: walk ptr, ptr+1, ... modulo 4 and take the first requester asking.
   function automatic logic [1:0] rr_pick(input logic [3:0] mask, input int ptr);
      logic [1:0] i;
      logic [3:0] t;
      for (int k = 0; k < NR; k++) begin
         i = 2'(ptr + k);
         t = mask >> i;
         if (t[0]) return i;
      end
      return 2'd0;
   endfunction

   task automatic chk_quiet(input string tag);
      chk({tag, "_send_val"}, 128'(spi_send_val), 128'(1'b0));
      chk({tag, "_cs_val"}, 128'(spi_cs_addr_val), 128'(1'b0));
      chk({tag, "_recv_rdy"}, 128'(req_recv_rdy), 128'(4'b0));
      chk({tag, "_send_val_req"}, 128'(req_send_val), 128'(4'b0));
      chk({tag, "_spi_recv_rdy"}, 128'(spi_recv_rdy), 128'(1'b0));
   endtask

   task automatic do_reset;
      reset        = 1'b1;
      req_recv_val = '0;
      req_recv_msg = '0;
      req_send_rdy = '0;
      spi_send_rdy = 1'b0;
      spi_recv_val = 1'b0;
      spi_recv_msg = '0;
      tick;
      tick;
      reset = 1'b0;
      chk_quiet("reset");
      m_ptr = 0;
   endtask

   task automatic do_txn(input logic [3:0] mask, input logic [127:0] msgs, input int send_stall,
                         input int resp_stall, input logic [31:0] resp, output logic [1:0] g_obs);
      logic [1:0]  g;
      logic [31:0] gmsg;
      logic [3:0]  onehot;
      g      = rr_pick(mask, m_ptr);
      gmsg   = 32'(msgs >> (32 * int'(g)));
      onehot = 4'b0001 << g;
      req_recv_msg = msgs;
      req_recv_val = mask;
      spi_send_rdy = 1'b0;
      spi_recv_val = 1'b0;
      req_send_rdy = '0;
      tick;
      g_obs = spi_cs_addr;
      chk("latency_send_val", 128'(spi_send_val), 128'(1'b1));
      for (int s = 0; s < send_stall; s++) begin
         if (s > 0) req_recv_val = 4'($urandom);
         spi_recv_val = 1'b1;
         spi_recv_msg = $urandom;
         req_send_rdy = 4'($urandom);
         #1;
         chk("stall_send_val", 128'(spi_send_val), 128'(1'b1));
         chk("stall_cs_val", 128'(spi_cs_addr_val), 128'(1'b1));
         chk("stall_cs_addr", 128'(spi_cs_addr), 128'(g));
         chk("stall_send_msg", 128'(spi_send_msg), 128'(gmsg));
         chk("stall_recv_rdy", 128'(req_recv_rdy), 128'(4'b0));
         chk("early_resp_rdy", 128'(spi_recv_rdy), 128'(1'b0));
         chk("early_resp_val", 128'(req_send_val), 128'(4'b0));
         tick;
      end
      spi_recv_val = 1'b0;
      req_send_rdy = '0;
      spi_send_rdy = 1'b1;
      #1;
      chk("xfer_cs_addr", 128'(spi_cs_addr), 128'(g));
      chk("xfer_send_msg", 128'(spi_send_msg), 128'(gmsg));
      chk("xfer_recv_rdy", 128'(req_recv_rdy), 128'(onehot));
      chk("xfer_spi_recv_rdy", 128'(spi_recv_rdy), 128'(1'b0));
      tick;
      spi_send_rdy = 1'b0;
      req_recv_val = mask & ~onehot;
      spi_recv_msg = resp;
      for (int s = 0; s < resp_stall; s++) begin
         spi_recv_val = 1'b1;
         req_send_rdy = 4'($urandom) & ~onehot;
         #1;
         chk("wait_send_val", 128'(spi_send_val), 128'(1'b0));
         chk("wait_recv_rdy", 128'(req_recv_rdy), 128'(4'b0));
         chk("wait_stall_rdy", 128'(spi_recv_rdy), 128'(1'b0));
         chk("wait_req_val", 128'(req_send_val), 128'(onehot));
         chk("wait_req_msg", 128'(req_send_msg), {4{resp}});
         tick;
      end
      spi_recv_val = 1'b1;
      req_send_rdy = 4'($urandom) | onehot;
      #1;
      chk("resp_spi_rdy", 128'(spi_recv_rdy), 128'(1'b1));
      chk("resp_req_val", 128'(req_send_val), 128'(onehot));
      chk("resp_req_msg", 128'(req_send_msg), {4{resp}});
      tick;
      spi_recv_val = 1'b0;
      req_send_rdy = '0;
      chk_quiet("back_idle");
      m_ptr = (int'(g) + 1) % NR;
   endtask

   initial begin
      logic [1:0] g;
      logic [3:0] mask;

      do_reset;

      // Single request from requester 0.
      do_txn(4'b0001, {96'(0), 32'hA5A5A5A5}, 0, 0, 32'h12345678, g);
      chk("single_grant", 128'(g), 128'(2'd0));

      // Two requesters contending from reset alternate.
      do_reset;
      for (int n = 0; n < 4; n++) begin
         do_txn(4'b0011, {$urandom, $urandom, $urandom, $urandom}, 0, 0, $urandom, g);
         chk("contention_seq", 128'(g), 128'(n % 2));
      end

      // SPI backpressure in SEND, then response stall in WAIT.
      do_txn(4'b0100, {$urandom, $urandom, $urandom, $urandom}, 5, 0, $urandom, g);
      do_txn(4'b1000, {$urandom, $urandom, $urandom, $urandom}, 0, 3, $urandom, g);

      // Reset while waiting for a response abandons it and clears ptr.
      do_txn(4'b0010, {$urandom, $urandom, $urandom, $urandom}, 0, 0, $urandom, g);
      req_recv_val = 4'b0100;
      req_recv_msg = {$urandom, $urandom, $urandom, $urandom};
      tick;
      chk("rst_pre_grant", 128'(spi_cs_addr), 128'(rr_pick(4'b0100, m_ptr)));
      spi_send_rdy = 1'b1;
      tick;
      spi_send_rdy = 1'b0;
      req_recv_val = '0;
      spi_recv_val = 1'b1;
      spi_recv_msg = $urandom;
      req_send_rdy = '0;
      #1;
      chk("rst_pre_wait", 128'(req_send_val), 128'(4'b0100));
      reset = 1'b1;
      tick;
      reset = 1'b0;
      req_send_rdy = '1;
      #1;
      chk_quiet("rst_wait");
      m_ptr = 0;
      tick;
      chk_quiet("rst_no_resp");
      spi_recv_val = 1'b0;
      req_send_rdy = '0;
      do_txn(4'b0110, {$urandom, $urandom, $urandom, $urandom}, 0, 0, $urandom, g);
      chk("rst_new_grant", 128'(g), 128'(2'd1));

      // Pointer wrap past the last requester.
      do_reset;
      do_txn(4'b1000, {$urandom, $urandom, $urandom, $urandom}, 0, 0, $urandom, g);
      chk("wrap_grant3", 128'(g), 128'(2'd3));
      do_txn(4'b0001, {$urandom, $urandom, $urandom, $urandom}, 0, 0, $urandom, g);
      chk("wrap_grant0", 128'(g), 128'(2'd0));
      do_txn(4'b1001, {$urandom, $urandom, $urandom, $urandom}, 0, 0, $urandom, g);
      chk("wrap_scan", 128'(g), 128'(2'd3));

      // Random traffic against the model.
      for (int n = 0; n < 30; n++) begin
         mask = 4'($urandom_range(15, 1));
         do_txn(mask, {$urandom, $urandom, $urandom, $urandom},
                int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), $urandom, g);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
